// File: rtl/fpu_prog_sequencer_if.sv
// Bus bundle for the FPU program sequencer.
// Groups the UART input, the SRAM port, the issue handshake and the result FIFO.
interface fpu_prog_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              rx_dv_i;
    logic [7:0]        rx_byte_i;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_waddr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_re_o;
    logic [ADDR_W-1:0] mem_raddr_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              inst_valid_o;
    logic [DATA_W-1:0] inst_o;
    logic              inst_ready_i;
    logic              res_valid_i;
    logic [DATA_W-1:0] res_data_i;
    logic              res_pop_i;
    logic              res_valid_o;
    logic [DATA_W-1:0] res_data_o;
    logic              res_ovf_o;
    logic [ADDR_W:0]   prog_len_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        input  rx_dv_i, rx_byte_i, mem_rdata_i, inst_ready_i,
        input  res_valid_i, res_data_i, res_pop_i,
        output mem_we_o, mem_waddr_o, mem_wdata_o, mem_re_o, mem_raddr_o,
        output inst_valid_o, inst_o, res_valid_o, res_data_o, res_ovf_o,
        output prog_len_o, busy_o, done_o
    );

    modport slave (
        output rx_dv_i, rx_byte_i, mem_rdata_i, inst_ready_i,
        output res_valid_i, res_data_i, res_pop_i,
        input  mem_we_o, mem_waddr_o, mem_wdata_o, mem_re_o, mem_raddr_o,
        input  inst_valid_o, inst_o, res_valid_o, res_data_o, res_ovf_o,
        input  prog_len_o, busy_o, done_o
    );
endinterface

// File: rtl/fpu_prog_sequencer.sv
// UART program loader and in-order instruction issue sequencer for the FPU harness.
// Also buffers FPU results in a small FIFO toward the chip output.
module fpu_prog_sequencer #(
    parameter int                 ADDR_W    = 8,
    parameter int                 DATA_W    = 32,
    parameter int                 RES_DEPTH = 4,
    parameter logic [DATA_W-1:0]  END_WORD  = 'h0000_0FFF
) (
    input logic                  clk,
    input logic                  rst_l,
    fpu_prog_sequencer_if.master bus
);
    localparam int NB = DATA_W / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam logic [BW-1:0]   LAST_B   = BW'(NB - 1);
    localparam logic [ADDR_W:0] MEM_LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);
    localparam logic [PW:0]     FULL_CNT = (PW+1)'(RES_DEPTH);

    typedef enum logic [2:0] {
        LOAD, FETCH, WAIT, ISSUE, DONE
    } state_t;

    state_t            state, nxt;
    logic [BW-1:0]     cnt;
    logic [DATA_W-1:0] word_buf, asm_word;
    logic [ADDR_W:0]   prog_len, pc, pc_inc;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q, inst_q;
    logic              word_done, is_end;
    logic              mem_re, inst_valid, busy, done;

    logic [DATA_W-1:0] fifo_q [RES_DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [PW:0]       count;
    logic              ovf_q, full, push_ok, pop_ok;

    always_comb begin
        asm_word = word_buf;
        asm_word[{cnt, 3'b000} +: 8] = bus.rx_byte_i;
    end

    assign word_done = (state == LOAD) && bus.rx_dv_i && (cnt == LAST_B);
    assign is_end    = (asm_word == END_WORD);
    assign pc_inc    = pc + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_l) state <= LOAD;
        else        state <= nxt;
    end

    always_comb begin
        nxt        = state;
        mem_re     = 1'b0;
        inst_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            LOAD: begin
                if (word_done) begin
                    if (is_end) begin
                        if (prog_len != '0) nxt = FETCH;
                    end else if (prog_len == MEM_LAST) begin
                        nxt = FETCH;
                    end
                end
            end
            FETCH: begin
                mem_re = 1'b1;
                busy   = 1'b1;
                nxt    = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                nxt  = ISSUE;
            end
            ISSUE: begin
                inst_valid = 1'b1;
                busy       = 1'b1;
                if (bus.inst_ready_i) nxt = (pc_inc == prog_len) ? DONE : FETCH;
            end
            DONE: begin
                done = 1'b1;
                if (bus.rx_dv_i) nxt = LOAD;
            end
            default: nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            cnt      <= '0;
            word_buf <= '0;
            prog_len <= '0;
            pc       <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            inst_q   <= '0;
        end else begin
            we_q <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (bus.rx_dv_i) begin
                        word_buf <= asm_word;
                        cnt      <= (cnt == LAST_B) ? '0 : cnt + 1'b1;
                        if (cnt == LAST_B && !is_end) begin
                            we_q     <= 1'b1;
                            waddr_q  <= prog_len[ADDR_W-1:0];
                            wdata_q  <= asm_word;
                            prog_len <= prog_len + 1'b1;
                        end
                    end
                end
                WAIT: inst_q <= bus.mem_rdata_i;
                ISSUE: if (bus.inst_ready_i) pc <= pc_inc;
                // The waking byte is byte 0 of the next program.
                DONE: begin
                    if (bus.rx_dv_i) begin
                        prog_len <= '0;
                        pc       <= '0;
                        waddr_q  <= '0;
                        word_buf <= DATA_W'(bus.rx_byte_i);
                        cnt      <= BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign full    = (count == FULL_CNT);
    assign pop_ok  = bus.res_pop_i && (count != '0);
    assign push_ok = bus.res_valid_i && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (bus.res_valid_i && full && !pop_ok) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wptr] <= bus.res_data_i;
    end

    assign bus.mem_we_o     = we_q;
    assign bus.mem_waddr_o  = waddr_q;
    assign bus.mem_wdata_o  = wdata_q;
    assign bus.mem_re_o     = mem_re;
    assign bus.mem_raddr_o  = pc[ADDR_W-1:0];
    assign bus.inst_valid_o = inst_valid;
    assign bus.inst_o       = inst_q;
    assign bus.res_valid_o  = (count != '0);
    assign bus.res_data_o   = (count != '0) ? fifo_q[rptr] : '0;
    assign bus.res_ovf_o    = ovf_q;
    assign bus.prog_len_o   = prog_len;
    assign bus.busy_o       = busy;
    assign bus.done_o       = done;
endmodule
